// File: rtl/meu_serial_adder.sv
// Digit-serial adder: adds two WIDTH-bit operands DIGIT bits per clock, LSD first.
// Optional signed-overflow output is enabled by defining MEU_SERIAL_ADDER_OVF_EN.
module meu_serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             carry_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o
`ifdef MEU_SERIAL_ADDER_OVF_EN
    ,
    output logic             overflow_o
`endif
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [DIGIT:0]     slice_sum;
    logic [WIDTH-1:0]   acc_shift;
    logic               last_slice;
`ifdef MEU_SERIAL_ADDER_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    assign slice_sum  = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                      + {{DIGIT{1'b0}}, carry_q};
    assign last_slice = (cnt_q == CNT_W'(N - 1));

    // New digit enters at the top so the full sum is aligned after N slices.
    generate
        if (N == 1) begin : g_single
            assign acc_shift = slice_sum[DIGIT-1:0];
        end else begin : g_multi
            assign acc_shift = {slice_sum[DIGIT-1:0], acc_q[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef MEU_SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    carry_d = carry_i;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = slice_sum[DIGIT];
                acc_d   = acc_shift;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_slice) begin
                    state_d = DONE;
                    sum_d   = acc_shift;
                    cout_d  = slice_sum[DIGIT];
`ifdef MEU_SERIAL_ADDER_OVF_EN
                    // Equal operand signs with a differing result sign is signed overflow.
                    ovf_d   = (a_q[DIGIT-1] == b_q[DIGIT-1])
                            && (slice_sum[DIGIT-1] != a_q[DIGIT-1]);
`endif
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef MEU_SERIAL_ADDER_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef MEU_SERIAL_ADDER_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign sum_o       = sum_q;
    assign carry_o     = cout_q;
`ifdef MEU_SERIAL_ADDER_OVF_EN
    assign overflow_o  = ovf_q;
`endif

endmodule

// File: tb/tb_meu_serial_adder.sv
// Directed bench for meu_serial_adder (WIDTH=16, DIGIT=4): latency, sums, backpressure, reset abort.
module tb_meu_serial_adder;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [15:0] a_i;
    logic [15:0] b_i;
    logic        carry_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [15:0] sum_o;
    logic        carry_o;
`ifdef MEU_SERIAL_ADDER_OVF_EN
    logic        overflow_o;
`endif

    int checks = 0;
    int errors = 0;

    meu_serial_adder #(.WIDTH(16), .DIGIT(4)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .carry_i     (carry_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .sum_o       (sum_o),
        .carry_o     (carry_o)
`ifdef MEU_SERIAL_ADDER_OVF_EN
        ,
        .overflow_o  (overflow_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Presents operands for exactly one edge (the accept edge).
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic cin);
        in_valid_i = 1'b1;
        a_i        = a;
        b_i        = b;
        carry_i    = cin;
        tick();
        in_valid_i = 1'b0;
    endtask

    // Accept, then expect out_valid_o low for 3 edges and high after the 4th.
    task automatic runOp(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic cin);
        applyStimulus(a, b, cin);
        checkOutput({tag, "_busy"}, 32'(in_ready_o), 32'd0);
        repeat (3) tick();
        checkOutput({tag, "_early"}, 32'(out_valid_o), 32'd0);
        tick();
        checkOutput({tag, "_valid"}, 32'(out_valid_o), 32'd1);
    endtask

    task automatic releaseResult(input string tag);
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        checkOutput({tag, "_rel_valid"}, 32'(out_valid_o), 32'd0);
        checkOutput({tag, "_rel_ready"}, 32'(in_ready_o), 32'd1);
    endtask

    initial begin
        logic sawValid;
        rst_i       = 1'b1;
        in_valid_i  = 1'b0;
        a_i         = '0;
        b_i         = '0;
        carry_i     = 1'b0;
        out_ready_i = 1'b0;
        #7;
        checkOutput("rst_ready", 32'(in_ready_o), 32'd1);
        checkOutput("rst_valid", 32'(out_valid_o), 32'd0);
        checkOutput("rst_sum", 32'(sum_o), 32'd0);
        checkOutput("rst_carry", 32'(carry_o), 32'd0);
        rst_i = 1'b0;
        tick();

        // out_ready_i held high through CALC must not disturb anything.
        out_ready_i = 1'b1;
        runOp("add5555", 16'h1234, 16'h4321, 1'b0);
        checkOutput("add5555_sum", 32'(sum_o), 32'h5555);
        checkOutput("add5555_carry", 32'(carry_o), 32'd0);
        tick();
        out_ready_i = 1'b0;
        checkOutput("add5555_rel", 32'(in_ready_o), 32'd1);
        checkOutput("add5555_hold", 32'(sum_o), 32'h5555);

        runOp("wrap1", 16'hFFFF, 16'h0001, 1'b0);
        checkOutput("wrap1_sum", 32'(sum_o), 32'h0000);
        checkOutput("wrap1_carry", 32'(carry_o), 32'd1);
`ifdef MEU_SERIAL_ADDER_OVF_EN
        checkOutput("wrap1_ovf", 32'(overflow_o), 32'd0);
`endif
        releaseResult("wrap1");

        runOp("wrapcin", 16'hFFFF, 16'h0000, 1'b1);
        checkOutput("wrapcin_sum", 32'(sum_o), 32'h0000);
        checkOutput("wrapcin_carry", 32'(carry_o), 32'd1);
`ifdef MEU_SERIAL_ADDER_OVF_EN
        checkOutput("wrapcin_ovf", 32'(overflow_o), 32'd0);
`endif
        releaseResult("wrapcin");

        runOp("sovf", 16'h7FFF, 16'h0001, 1'b0);
        checkOutput("sovf_sum", 32'(sum_o), 32'h8000);
        checkOutput("sovf_carry", 32'(carry_o), 32'd0);
`ifdef MEU_SERIAL_ADDER_OVF_EN
        checkOutput("sovf_ovf", 32'(overflow_o), 32'd1);
`endif
        releaseResult("sovf");

        // Backpressure: result must hold for 5 cycles with out_ready_i low.
        runOp("bp", 16'h00FF, 16'h0F01, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("bp_sum", 32'(sum_o), 32'h1001);
            checkOutput("bp_valid", 32'(out_valid_o), 32'd1);
            checkOutput("bp_ready", 32'(in_ready_o), 32'd0);
        end
        checkOutput("bp_carry", 32'(carry_o), 32'd0);
        releaseResult("bp");

        // New operands offered during CALC are ignored.
        applyStimulus(16'h0001, 16'h0001, 1'b0);
        in_valid_i = 1'b1;
        a_i        = 16'hAAAA;
        b_i        = 16'hAAAA;
        carry_i    = 1'b1;
        repeat (3) tick();
        in_valid_i = 1'b0;
        checkOutput("ign_early", 32'(out_valid_o), 32'd0);
        tick();
        checkOutput("ign_valid", 32'(out_valid_o), 32'd1);
        checkOutput("ign_sum", 32'(sum_o), 32'h0002);
        checkOutput("ign_carry", 32'(carry_o), 32'd0);
        releaseResult("ign");

        // Reset in the second CALC cycle clears outputs without a clock edge.
        applyStimulus(16'h1111, 16'h2222, 1'b0);
        tick();
        #2;
        rst_i = 1'b1;
        #1;
        checkOutput("abort_sum", 32'(sum_o), 32'd0);
        checkOutput("abort_carry", 32'(carry_o), 32'd0);
        checkOutput("abort_ready", 32'(in_ready_o), 32'd1);
        checkOutput("abort_valid", 32'(out_valid_o), 32'd0);
        #1;
        rst_i = 1'b0;
        sawValid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid_o !== 1'b0) sawValid = 1'b1;
        end
        checkOutput("abort_novalid", 32'(sawValid), 32'd0);
        checkOutput("abort_idle", 32'(in_ready_o), 32'd1);

        runOp("msb", 16'h8000, 16'h8000, 1'b0);
        checkOutput("msb_sum", 32'(sum_o), 32'h0000);
        checkOutput("msb_carry", 32'(carry_o), 32'd1);
`ifdef MEU_SERIAL_ADDER_OVF_EN
        checkOutput("msb_ovf", 32'(overflow_o), 32'd1);
`endif
        releaseResult("msb");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
